spell_dbg_master: RTL and testbench

Host-side master for the SPELL core's serial debug port. Accepts parallel register read/write, single-step and run-control commands, and generates the core's `run`/`step`/`load`/`dump`/`shift_in`/`reg_sel` pins. It captures `shift_out` for reads and reports completion on a one-cycle response strobe. It sits between a host bus (UART bridge or harness) and the core's `ui_in`/`uo_out` pins.

---
 rtl/spell_dbg_pkg.sv | 32 +++
 rtl/spell_dbg_bit_timer.sv | 60 ++++++
 rtl/spell_dbg_master.sv | 169 ++++++++++++++++
 tb/tb_spell_dbg_master.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_dbg_pkg.sv
// Shared types and constants for the SPELL debug-port master.
package spell_dbg_pkg;

  localparam int DBG_DATA_W = 8;

  // Core register-select encodings
  localparam logic [1:0] REG_PC    = 2'd0;
  localparam logic [1:0] REG_SP    = 2'd1;
  localparam logic [1:0] REG_EXEC  = 2'd2;
  localparam logic [1:0] REG_STACK = 2'd3;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_READ    = 2'd1,
    OP_STEP    = 2'd2,
    OP_SET_RUN = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_W   = 3'd1,
    ST_SHIFT_R   = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // Step status word reported to the host: {6'b0, stop, sleep}
  function automatic logic [DBG_DATA_W-1:0] step_status(input logic stop, input logic sleep);
    return {6'b0, stop, sleep};
  endfunction

endpackage

// File: rtl/spell_dbg_bit_timer.sv
// Bit-period timer for the serial shift: DIV prescaler plus 3-bit bit counter.
// The counters describe the cycle AFTER the current one, so every strobe
// output announces the upcoming cycle and the parent can register the core
// pins directly from them. Shift k occupies cycles start+1+k*DIV .. start+(k+1)*DIV.
module spell_dbg_bit_timer #(
  parameter int DIV        = 2,
  parameter int SAMPLE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,       // one-cycle pulse on the accept cycle
  output logic       busy,        // a shift is in progress beyond the next cycle
  output logic       first_cyc,   // next cycle is the first of a bit period
  output logic       last_cyc,    // next cycle is the last of a bit period
  output logic       sample_cyc,  // next cycle is SAMPLE_LAT into a bit period
  output logic       done,        // next cycle is the last cycle of the whole shift
  output logic [2:0] bit_idx      // bit period index of the next cycle
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          act;
  logic          live;
  logic          at_last;

  assign live       = start | act;
  assign at_last    = (div_cnt == DW'(DIV - 1));
  assign busy       = act;
  assign first_cyc  = live & (div_cnt == '0);
  assign last_cyc   = live & at_last;
  assign sample_cyc = live & (div_cnt == DW'(SAMPLE_LAT));
  assign done       = last_cyc & (bit_cnt == 3'd7);
  assign bit_idx    = bit_cnt;

  // Advance the (next-cycle) position; return to rest after bit 7's last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (live) begin
      if (at_last) begin
        div_cnt <= '0;
        if (bit_cnt == 3'd7) begin
          act     <= 1'b0;
          bit_cnt <= '0;
        end else begin
          act     <= 1'b1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        act     <= 1'b1;
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/spell_dbg_master.sv
// Host-side master for the SPELL serial debug port: register write/read
// shifts, single-step with timeout, and run-level control.
//
// Handshake: a command transfers on the cycle where cmd_valid & cmd_ready are
// both high; cmd_ready is high only in IDLE (and never during reset), so the
// host must hold cmd_valid and its fields until it sees the transfer. The
// response is a single-cycle rsp_valid strobe with no backpressure;
// rsp_data/rsp_err are zero whenever rsp_valid is low.
module spell_dbg_master
  import spell_dbg_pkg::*;
#(
  parameter int DIV          = 2,
  parameter int SAMPLE_LAT   = 1,
  parameter int STEP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [1:0]            cmd_reg,
  input  logic [DBG_DATA_W-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DBG_DATA_W-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  o_run,
  output logic                  o_step,
  output logic                  o_load,
  output logic                  o_dump,
  output logic                  o_shift_in,
  output logic [1:0]            o_reg_sel,
  input  logic                  i_cpu_sleep,
  input  logic                  i_cpu_stop,
  input  logic                  i_cpu_wait_delay,
  input  logic                  i_shift_out,
  output state_e                dbg_state
);

  localparam int TW = $clog2(STEP_TIMEOUT + 1);

  state_e                state, state_nxt;
  op_e                   op_in;
  logic                  accept;
  logic                  tmr_start, tmr_busy, tmr_first, tmr_last, tmr_sample, tmr_done;
  logic [2:0]            tmr_bit;
  logic                  is_wr, is_rd;
  logic [DBG_DATA_W-1:0] data_sel, data_q;
  logic [DBG_DATA_W-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic                  sample_now, last_now;
  logic [TW-1:0]         wait_cnt;
  logic                  watching, step_done, step_timeout;

  assign op_in     = op_e'(cmd_op);
  assign cmd_ready = rst_n & (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign tmr_start = accept & ((op_in == OP_WRITE) | (op_in == OP_READ));

  // In IDLE the shift kind and data come straight from the accepted command;
  // afterwards from the state and latched data.
  assign is_wr    = (state == ST_IDLE) ? (op_in == OP_WRITE) : (state == ST_SHIFT_W);
  assign is_rd    = (state == ST_IDLE) ? (op_in == OP_READ)  : (state == ST_SHIFT_R);
  assign data_sel = (state == ST_IDLE) ? cmd_data : data_q;

  // The pulse cycle itself is not inspected; completion counts from the next one
  assign watching     = (state == ST_STEP_WAIT) & ~o_step;
  assign step_done    = (i_cpu_sleep | i_cpu_stop) & ~i_cpu_wait_delay;
  assign step_timeout = (wait_cnt == TW'(STEP_TIMEOUT - 1));

  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = rsp_valid ? rsp_data_q : '0;
  assign rsp_err   = rsp_valid & rsp_err_q;
  assign dbg_state = state;

  spell_dbg_bit_timer #(
    .DIV        (DIV),
    .SAMPLE_LAT (SAMPLE_LAT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (tmr_start),
    .busy       (tmr_busy),
    .first_cyc  (tmr_first),
    .last_cyc   (tmr_last),
    .sample_cyc (tmr_sample),
    .done       (tmr_done),
    .bit_idx    (tmr_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_in)
            OP_WRITE: state_nxt = ST_SHIFT_W;
            OP_READ:  state_nxt = ST_SHIFT_R;
            OP_STEP:  state_nxt = o_run ? ST_RESP : ST_STEP_WAIT;
            default:  state_nxt = ST_RESP;
          endcase
        end
      end
      ST_SHIFT_W, ST_SHIFT_R: if (last_now) state_nxt = ST_RESP;
      ST_STEP_WAIT: if (watching & (step_done | step_timeout)) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered core pins, driven one cycle ahead from the timer's announcements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_load     <= 1'b0;
      o_dump     <= 1'b0;
      o_shift_in <= 1'b0;
      o_step     <= 1'b0;
      o_run      <= 1'b0;
      o_reg_sel  <= 2'd0;
      data_q     <= '0;
      sample_now <= 1'b0;
      last_now   <= 1'b0;
    end else begin
      o_load     <= tmr_last & is_wr;
      o_dump     <= tmr_first & is_rd;
      o_shift_in <= is_wr & (tmr_start | tmr_busy) & data_sel[3'd7 - tmr_bit];
      o_step     <= accept & (op_in == OP_STEP) & ~o_run;
      sample_now <= tmr_sample & is_rd;
      last_now   <= tmr_done;
      if (accept) begin
        o_reg_sel <= cmd_reg;
        data_q    <= cmd_data;
      end
      if (accept & (op_in == OP_SET_RUN)) o_run <= cmd_data[0];
    end
  end

  // Response payload: read shift register, step status and the step wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wait_cnt   <= '0;
    end else if (accept) begin
      rsp_data_q <= '0;
      rsp_err_q  <= (op_in == OP_STEP) & o_run;
      wait_cnt   <= '0;
    end else if ((state == ST_SHIFT_R) & sample_now) begin
      rsp_data_q <= {rsp_data_q[DBG_DATA_W-2:0], i_shift_out};
    end else if (watching) begin
      if (step_done) begin
        rsp_data_q <= step_status(i_cpu_stop, i_cpu_sleep);
        rsp_err_q  <= 1'b0;
      end else if (step_timeout) begin
        rsp_data_q <= step_status(i_cpu_stop, i_cpu_sleep);
        rsp_err_q  <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spell_dbg_master.sv
// Self-checking bench for spell_dbg_master: directed vector table, hand-written
// reset sequence and randomized commands against a behavioural model.
module tb_spell_dbg_master;
  import spell_dbg_pkg::*;

  localparam int DIV = 2;
  localparam int SL  = 1;
  localparam int TO  = 16;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_reg;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic        o_run, o_step, o_load, o_dump, o_shift_in;
  logic [1:0]  o_reg_sel;
  logic        i_cpu_sleep, i_cpu_stop, i_cpu_wait_delay, i_shift_out;
  state_e      dbg_state;

  spell_dbg_master #(.DIV(DIV), .SAMPLE_LAT(SL), .STEP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .o_run(o_run), .o_step(o_step), .o_load(o_load), .o_dump(o_dump),
    .o_shift_in(o_shift_in), .o_reg_sel(o_reg_sel),
    .i_cpu_sleep(i_cpu_sleep), .i_cpu_stop(i_cpu_stop),
    .i_cpu_wait_delay(i_cpu_wait_delay), .i_shift_out(i_shift_out),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / monitor ----------------
  int          checks = 0;
  int          failures = 0;
  logic [8:0]  exp_q[$];
  int          load_cyc[$];
  logic        load_bit[$];
  int          dump_cyc[$];
  int          step_cyc[$];
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  int          idle_bad = 0;
  logic [8:0]  exp_w;

  always @(negedge clk) begin
    if (o_load) begin
      load_cyc.push_back(cyc);
      load_bit.push_back(o_shift_in);
    end
    if (o_dump) dump_cyc.push_back(cyc);
    if (o_step) step_cyc.push_back(cyc);
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got 0x%0h at cycle %0d, required no response", {rsp_err, rsp_data}, cyc);
      end else begin
        exp_w = exp_q.pop_front();
        if ({rsp_err, rsp_data} !== exp_w) begin
          failures++;
          $display("FAIL rsp_word: got {err,data}=0x%0h, required 0x%0h", {rsp_err, rsp_data}, exp_w);
        end
      end
    end else if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin
      idle_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  // Each dump strobe presents the next register bit (MSB first) from the
  // following cycle; during the strobe cycle itself the pin carries the
  // inverted bit so early or late sampling is visible.
  logic [7:0] core_val = 8'h00;
  int         core_n = 0;
  logic       core_b;

  initial begin
    i_shift_out = 1'b0;
    forever begin
      @(negedge clk);
      if (o_dump === 1'b1) begin
        core_b = (core_n < 8) ? core_val[7 - core_n] : 1'b0;
        i_shift_out = ~core_b;
        @(posedge clk);
        #1;
        i_shift_out = core_b;
        core_n++;
      end
    end
  end

  // Core status for a step: status appears sa cycles after the pulse,
  // wait_delay is held for wdl cycles from that point.
  function automatic void pins_at(input int r, input int sa, input logic [1:0] kind, input int wdl,
                                  output logic sl, output logic st, output logic wd);
    logic act;
    act = (r >= sa);
    sl  = act & kind[0];
    st  = act & kind[1];
    wd  = act & (r < sa + wdl);
  endfunction

  // ---------------- reference model ----------------
  function automatic void model(input op_e op, input logic [7:0] core, input logic run,
                                input int sa, input logic [1:0] kind, input int wdl,
                                output int lat, output logic [8:0] rsp);
    logic sl, st, wd, found;
    lat = 1;
    rsp = 9'h000;
    case (op)
      OP_WRITE: lat = 8 * DIV + 1;
      OP_READ: begin
        lat = 8 * DIV + 1;
        rsp = {1'b0, core};
      end
      OP_SET_RUN: lat = 1;
      default: begin
        if (run) begin
          rsp = 9'h100;
        end else begin
          found = 1'b0;
          for (int r = 1; r <= TO; r++) begin
            if (!found) begin
              pins_at(r, sa, kind, wdl, sl, st, wd);
              if ((sl | st) & ~wd) begin
                found = 1'b1;
                lat   = r + 2;
                rsp   = {1'b0, 6'b0, st, sl};
              end
            end
          end
          if (!found) begin
            pins_at(TO, sa, kind, wdl, sl, st, wd);
            lat = TO + 2;
            rsp = {1'b1, 6'b0, st, sl};
          end
        end
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic clear_logs();
    load_cyc.delete();
    load_bit.delete();
    dump_cyc.delete();
    step_cyc.delete();
  endtask

  task automatic issue(input op_e op, input logic [1:0] rg, input logic [7:0] data,
                       input string tag, output int t);
    logic got;
    got = 1'b0;
    t = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = rg;
        cmd_data  = data;
        t         = cyc;
        got       = 1'b1;
      end
    end
    check({tag, "_accepted"}, got, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_reg   = 2'($urandom_range(0, 3));
    cmd_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic run_cmd(input op_e op, input logic [1:0] rg, input logic [7:0] data,
                         input logic [7:0] core, input int sa, input logic [1:0] kind,
                         input int wdl, input int exp_lat, input logic [8:0] exp_rsp,
                         input logic exp_run, input int exp_steps, input string tag);
    int   t, rc0;
    logic done, sl, st, wd;
    clear_logs();
    core_val = core;
    core_n   = 0;
    exp_q.push_back(exp_rsp);
    rc0 = rsp_cnt;
    issue(op, rg, data, tag, t);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      pins_at(cyc - (t + 1), sa, kind, wdl, sl, st, wd);
      i_cpu_sleep      = sl;
      i_cpu_stop       = st;
      i_cpu_wait_delay = wd;
      // commands offered while busy must be ignored
      cmd_valid = (cyc < t + exp_lat) ? 1'b1 : 1'b0;
      #1;
      if (rsp_cnt != rc0) done = 1'b1;
    end
    cmd_valid        = 1'b0;
    i_cpu_sleep      = 1'b0;
    i_cpu_stop       = 1'b0;
    i_cpu_wait_delay = 1'b0;
    check({tag, "_rsp_seen"}, done, 1);
    check({tag, "_latency"}, rsp_cyc - t, exp_lat);
    check({tag, "_reg_sel"}, o_reg_sel, rg);
    check({tag, "_run"}, o_run, exp_run);
    check({tag, "_loads"}, load_cyc.size(), (op == OP_WRITE) ? 8 : 0);
    for (int k = 0; k < load_cyc.size() && k < 8; k++) begin
      check({tag, "_load_cyc"}, load_cyc[k] - t, DIV * (k + 1));
      check({tag, "_load_bit"}, load_bit[k], data[7 - k]);
    end
    check({tag, "_dumps"}, dump_cyc.size(), (op == OP_READ) ? 8 : 0);
    for (int k = 0; k < dump_cyc.size() && k < 8; k++)
      check({tag, "_dump_cyc"}, dump_cyc[k] - t, 1 + k * DIV);
    check({tag, "_steps"}, step_cyc.size(), exp_steps);
    if (step_cyc.size() > 0) check({tag, "_step_cyc"}, step_cyc[0] - t, 1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    op_e        op;
    logic [1:0] rg;
    logic [7:0] data;
    logic [7:0] core;
    int         sa;
    logic [1:0] kind;
    int         wdl;
    int         lat;
    logic [8:0] rsp;
    logic       run;
    int         steps;
  } vec_t;

  vec_t tbl[13];
  logic model_run = 1'b0;

  initial begin
    int         t, rc0, lat, steps;
    logic [8:0] rsp;
    op_e        op;
    logic [1:0] rg, kind;
    logic [7:0] data, core;
    int         sa, wdl;

    //              op          reg        data   core   sa  kind wdl lat  rsp     run steps
    tbl[0]  = '{OP_WRITE,   REG_SP,    8'hA5, 8'h00, 99, 2'd0, 0, 17, 9'h000, 1'b0, 0};
    tbl[1]  = '{OP_READ,    REG_EXEC,  8'h00, 8'h3C, 99, 2'd0, 0, 17, 9'h03C, 1'b0, 0};
    tbl[2]  = '{OP_STEP,    REG_PC,    8'h00, 8'h00,  5, 2'd1, 0,  7, 9'h001, 1'b0, 1};
    tbl[3]  = '{OP_STEP,    REG_PC,    8'h00, 8'h00,  5, 2'd1, 3, 10, 9'h001, 1'b0, 1};
    tbl[4]  = '{OP_STEP,    REG_PC,    8'h00, 8'h00, 99, 2'd0, 0, 18, 9'h100, 1'b0, 1};
    tbl[5]  = '{OP_STEP,    REG_SP,    8'h00, 8'h00,  3, 2'd2, 0,  5, 9'h002, 1'b0, 1};
    tbl[6]  = '{OP_STEP,    REG_PC,    8'h00, 8'h00, 10, 2'd3, 20, 18, 9'h103, 1'b0, 1};
    tbl[7]  = '{OP_STEP,    REG_PC,    8'h00, 8'h00, 16, 2'd1, 0, 18, 9'h001, 1'b0, 1};
    tbl[8]  = '{OP_SET_RUN, REG_PC,    8'h01, 8'h00, 99, 2'd0, 0,  1, 9'h000, 1'b1, 0};
    tbl[9]  = '{OP_STEP,    REG_EXEC,  8'h00, 8'h00,  2, 2'd1, 0,  1, 9'h100, 1'b1, 0};
    tbl[10] = '{OP_SET_RUN, REG_PC,    8'hFE, 8'h00, 99, 2'd0, 0,  1, 9'h000, 1'b0, 0};
    tbl[11] = '{OP_WRITE,   REG_STACK, 8'h5A, 8'h00, 99, 2'd0, 0, 17, 9'h000, 1'b0, 0};
    tbl[12] = '{OP_READ,    REG_PC,    8'h00, 8'h81, 99, 2'd0, 0, 17, 9'h081, 1'b0, 0};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_reg = 2'd0; cmd_data = 8'h00;
    i_cpu_sleep = 1'b0; i_cpu_stop = 1'b0; i_cpu_wait_delay = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_err, o_run, o_step,
                            o_load, o_dump, o_shift_in, o_reg_sel}, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 13; i++) begin
      run_cmd(tbl[i].op, tbl[i].rg, tbl[i].data, tbl[i].core, tbl[i].sa, tbl[i].kind,
              tbl[i].wdl, tbl[i].lat, tbl[i].rsp, tbl[i].run, tbl[i].steps,
              $sformatf("vec%0d", i));
      model_run = tbl[i].run;
    end

    // reset in the middle of a write, with the core running
    run_cmd(OP_SET_RUN, REG_PC, 8'h01, 8'h00, 99, 2'd0, 0, 1, 9'h000, 1'b1, 0, "pre_rst_run");
    clear_logs();
    rc0 = rsp_cnt;
    issue(OP_WRITE, REG_STACK, 8'hC3, "rst_wr", t);
    for (int i = 0; i < 40 && load_cyc.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_loads", load_cyc.size(), 3);
    check("rst_mid_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_err, o_run, o_step,
                              o_load, o_dump, o_shift_in, o_reg_sel}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_ready", cmd_ready, 1);
    repeat (25) @(negedge clk);
    check("rst_mid_no_rsp", rsp_cnt - rc0, 0);
    check("rst_mid_no_more_loads", load_cyc.size(), 3);
    model_run = 1'b0;
    run_cmd(OP_READ, REG_EXEC, 8'h00, 8'hC3, 99, 2'd0, 0, 17, 9'h0C3, 1'b0, 0, "post_rst_rd");

    // randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      op   = op_e'($urandom_range(0, 3));
      rg   = 2'($urandom_range(0, 3));
      data = 8'($urandom_range(0, 255));
      core = 8'($urandom_range(0, 255));
      sa   = $urandom_range(1, 20);
      kind = 2'($urandom_range(0, 3));
      wdl  = $urandom_range(0, 4);
      model(op, core, model_run, sa, kind, wdl, lat, rsp);
      steps = ((op == OP_STEP) && !model_run) ? 1 : 0;
      if (op == OP_SET_RUN) model_run = data[0];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(op, rg, data, core, sa, kind, wdl, lat, rsp, model_run, steps,
              $sformatf("rnd%0d", i));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_rsp_zero", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
